// File: rtl/dsha_job_controller_pkg.sv
// Shared definitions for the dsha job controller.
// Contents: job word field offsets and widths, the control state encoding,
// the result entry layout (hash above nonce) and its total width.
package dsha_ctrl_pkg;

  // Field offsets inside the 416-bit job word from the UART receiver
  localparam int unsigned X_LSB     = 0;
  localparam int unsigned Y_LSB     = 256;
  localparam int unsigned START_LSB = 352;
  localparam int unsigned END_LSB   = 384;
  localparam int unsigned JOB_W     = 416;

  localparam int unsigned X_W     = 256;
  localparam int unsigned Y_W     = 96;
  localparam int unsigned NONCE_W = 32;
  localparam int unsigned HASH_W  = 256;
  localparam int unsigned RES_W   = HASH_W + NONCE_W;

  // Control state encoding
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

  // One queued hit; packs to exactly RES_W bits
  typedef struct packed {
    logic [HASH_W-1:0]  hash;
    logic [NONCE_W-1:0] nonce;
  } result_t;

endpackage

// File: rtl/dsha_job_controller_if.sv
// Bundle of every non-clock signal of the dsha job controller.
//   master : the controller itself (drives job_ack, dsha_X/Y/nonce, res_*, busy,
//            exhausted, overflow; samples job_*, dsha_accepted/hash/out_nonce, res_ready)
//   slave  : the surrounding blocks (UART receiver, dsha_finisher, UART transmitter)
interface dsha_job_controller_if;
  import dsha_ctrl_pkg::*;

  logic               job_valid;
  logic [JOB_W-1:0]   job_data;
  logic               job_ack;
  logic [X_W-1:0]     dsha_X;
  logic [Y_W-1:0]     dsha_Y;
  logic [NONCE_W-1:0] dsha_nonce;
  logic               dsha_accepted;
  logic [HASH_W-1:0]  dsha_hash;
  logic [NONCE_W-1:0] dsha_out_nonce;
  logic               res_valid;
  logic [HASH_W-1:0]  res_hash;
  logic [NONCE_W-1:0] res_nonce;
  logic               res_ready;
  logic               busy;
  logic               exhausted;
  logic               overflow;

  modport master (
    input  job_valid, job_data, dsha_accepted, dsha_hash, dsha_out_nonce, res_ready,
    output job_ack, dsha_X, dsha_Y, dsha_nonce, res_valid, res_hash, res_nonce,
           busy, exhausted, overflow
  );

  modport slave (
    output job_valid, job_data, dsha_accepted, dsha_hash, dsha_out_nonce, res_ready,
    input  job_ack, dsha_X, dsha_Y, dsha_nonce, res_valid, res_hash, res_nonce,
           busy, exhausted, overflow
  );
endinterface

// File: rtl/dsha_job_controller_result_fifo.sv
// result_fifo: synchronous FIFO holding hits until the UART transmitter takes them.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears every entry)
//   push       write push_data (ignored when full unless a pop happens the same cycle)
//   push_data  W-bit entry
//   pop        remove head (ignored when empty)
//   valid      FIFO holds at least one entry (registered)
//   full       FIFO holds 2**LOG entries (registered)
//   head       oldest entry
module result_fifo #(
  parameter int unsigned W   = 288,
  parameter int unsigned LOG = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic         full,
  output logic [W-1:0] head
);

  localparam int unsigned DEPTH = 1 << LOG;
  localparam int unsigned CW    = LOG + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE_C   = CW'(1);
  localparam logic [LOG-1:0] PTR_ONE = LOG'(1);

  logic [W-1:0]   mem_r [DEPTH];
  logic [LOG-1:0] wr_ptr_r;
  logic [LOG-1:0] rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           valid_r;
  logic           full_r;

  logic           do_pop_s;
  logic           do_push_s;
  logic [CW-1:0]  count_nxt_s;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop_s  = pop & valid_r;
  assign do_push_s = push & (~full_r | do_pop_s);

  // Next occupancy from the push/pop combination
  always_comb begin
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {LOG{1'b0}};
      rd_ptr_r <= {LOG{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CW{1'b0}});
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  assign valid = valid_r;
  assign full  = full_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/dsha_job_controller.sv
// dsha_job_controller: runs one mining job at a time through dsha_finisher.
// Latches a job (X, Y, nonce range), streams nonces, screens every pipeline output
// for ZBITS leading zeros, queues hits for the UART transmitter, ignores results
// of an aborted job and reports range exhaustion.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  dsha_job_controller_if.master: job_valid/job_data/job_ack (job input),
//        dsha_X/Y/nonce/accepted/hash/out_nonce (datapath), res_valid/hash/nonce/ready
//        (result queue), busy, exhausted, overflow (status)
module dsha_job_controller
  import dsha_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 130,
  parameter int unsigned ZBITS      = 16,
  parameter int unsigned FIFO_LOG   = 2
) (
  input logic                  clk,
  input logic                  rst,
  dsha_job_controller_if.master bus
);

  localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(PIPE_DEPTH);
  // The DRAIN->DONE edge itself is the last of PIPE_DEPTH cycles
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t             state_r;
  logic [X_W-1:0]     x_r;
  logic [Y_W-1:0]     y_r;
  logic [NONCE_W-1:0] nonce_r;
  logic [NONCE_W-1:0] end_r;
  logic [CNT_W-1:0]   drain_cnt_r;
  logic [CNT_W-1:0]   flush_cnt_r;
  logic               job_ack_r;
  logic               busy_r;
  logic               exhausted_r;
  logic               overflow_r;
  logic               last_hit_vld_r;
  logic [NONCE_W-1:0] last_hit_nonce_r;

  logic    live_s;
  logic    top_zero_s;
  logic    dup_s;
  logic    qualify_s;
  logic    fifo_valid_s;
  logic    fifo_full_s;
  logic    pop_s;
  logic    drop_s;
  result_t push_s;
  result_t head_s;

  assign live_s     = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign top_zero_s = (bus.dsha_hash[HASH_W-1 -: ZBITS] == {ZBITS{1'b0}});
  // The datapath holds its output between accepts, so a repeated nonce is the same result
  assign dup_s      = last_hit_vld_r && (bus.dsha_out_nonce == last_hit_nonce_r);
  assign qualify_s  = live_s && (flush_cnt_r == {CNT_W{1'b0}}) && top_zero_s && !dup_s;
  assign pop_s      = fifo_valid_s & bus.res_ready;
  assign drop_s     = qualify_s & fifo_full_s & ~pop_s;
  assign push_s     = '{hash: bus.dsha_hash, nonce: bus.dsha_out_nonce};

  // Control FSM: job latch (any state, wins over everything), nonce stream, drain timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      x_r         <= {X_W{1'b0}};
      y_r         <= {Y_W{1'b0}};
      nonce_r     <= {NONCE_W{1'b0}};
      end_r       <= {NONCE_W{1'b0}};
      drain_cnt_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      exhausted_r <= 1'b0;
    end else if (bus.job_valid) begin
      state_r     <= ST_RUN;
      x_r         <= bus.job_data[X_LSB +: X_W];
      y_r         <= bus.job_data[Y_LSB +: Y_W];
      nonce_r     <= bus.job_data[START_LSB +: NONCE_W];
      end_r       <= bus.job_data[END_LSB +: NONCE_W];
      drain_cnt_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b1;
      exhausted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
        end
        ST_RUN: begin
          if (bus.dsha_accepted) begin
            if (nonce_r == end_r) begin
              // end is inclusive: the nonce holds and the pipeline drains
              state_r     <= ST_DRAIN;
              drain_cnt_r <= DRAIN_LOAD;
            end else begin
              nonce_r <= nonce_r + 32'd1;
            end
          end else begin
            nonce_r <= nonce_r;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == {CNT_W{1'b0}}) begin
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            exhausted_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - CNT_ONE;
          end
        end
        ST_DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // job_ack echoes job_valid one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_ack_r <= 1'b0;
    end else begin
      job_ack_r <= bus.job_valid;
    end
  end

  // Results still in flight from the previous job are ignored for one pipeline depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.job_valid) begin
      flush_cnt_r <= FLUSH_LOAD;
    end else if (flush_cnt_r != {CNT_W{1'b0}}) begin
      flush_cnt_r <= flush_cnt_r - CNT_ONE;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  // Remember the last reported nonce for duplicate suppression
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_hit_vld_r   <= 1'b0;
      last_hit_nonce_r <= {NONCE_W{1'b0}};
    end else if (qualify_s) begin
      last_hit_vld_r   <= 1'b1;
      last_hit_nonce_r <= bus.dsha_out_nonce;
    end else begin
      last_hit_vld_r   <= last_hit_vld_r;
      last_hit_nonce_r <= last_hit_nonce_r;
    end
  end

  // Sticky overflow; a drop in the same cycle as a job latch is still reported
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (bus.job_valid) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  result_fifo #(
    .W   (RES_W),
    .LOG (FIFO_LOG)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (qualify_s),
    .push_data (push_s),
    .pop       (pop_s),
    .valid     (fifo_valid_s),
    .full      (fifo_full_s),
    .head      (head_s)
  );

  assign bus.job_ack    = job_ack_r;
  assign bus.dsha_X     = x_r;
  assign bus.dsha_Y     = y_r;
  assign bus.dsha_nonce = nonce_r;
  assign bus.res_valid  = fifo_valid_s;
  assign bus.res_hash   = head_s.hash;
  assign bus.res_nonce  = head_s.nonce;
  assign bus.busy       = busy_r;
  assign bus.exhausted  = exhausted_r;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_dsha_job_controller.sv
// Bench for dsha_job_controller: fixed-latency model of dsha_finisher with per-nonce
// forced hashes, scoreboard of expected FIFO results, direct status checks.
module tb_dsha_job_controller;
  import dsha_ctrl_pkg::*;

  localparam int PD = 130;

  typedef struct packed {
    logic [255:0] hash;
    logic [31:0]  nonce;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   n_res;
  exp_t sb_q[$];
  logic [31:0] hit_list[$];

  dsha_job_controller_if bus ();

  dsha_job_controller #(
    .PIPE_DEPTH (PD),
    .ZBITS      (16),
    .FIFO_LOG   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison and failure reporting for every check in the bench
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_hit(input logic [31:0] n);
    logic h;
    h = 1'b0;
    foreach (hit_list[i]) if (hit_list[i] == n) h = 1'b1;
    return h;
  endfunction

  function automatic logic [255:0] hash_for(input logic [31:0] n);
    logic [255:0] h;
    h = {8{n ^ 32'h5A5A_3C3C}};
    if (is_hit(n)) h[255:240] = 16'h0000;
    else h[255] = 1'b1;
    return h;
  endfunction

  // dsha_finisher model: nonce accepted at edge k appears on the outputs after edge k+PD-1
  logic        pv [0:PD-2];
  logic [31:0] pn [0:PD-2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PD-1; i++) pv[i] <= 1'b0;
      bus.dsha_out_nonce <= 32'hDEAD_BEEF;
      bus.dsha_hash      <= {256{1'b1}};
    end else begin
      pv[0] <= bus.dsha_accepted;
      pn[0] <= bus.dsha_nonce;
      for (int i = 1; i < PD-1; i++) begin
        pv[i] <= pv[i-1];
        pn[i] <= pn[i-1];
      end
      if (pv[PD-2]) begin
        bus.dsha_out_nonce <= pn[PD-2];
        bus.dsha_hash      <= hash_for(pn[PD-2]);
      end
    end
  end

  // Scoreboard: every popped head must be the next expected hit
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        chk("res_unexpected", 256'(sb_q.size()), 256'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res_nonce", 256'(bus.res_nonce), 256'(e.nonce));
        chk("res_hash", bus.res_hash, e.hash);
      end
      n_res++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic expect_hit(input logic [31:0] n);
    sb_q.push_back('{hash: hash_for(n), nonce: n});
  endtask

  task automatic load_job(input logic [31:0] s, input logic [31:0] e);
    bus.job_data = {e, s, {3{~s}}, {8{s ^ 32'hA5A5_0000}}};
  endtask

  task automatic wait_sb(input string tag);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    chk(tag, 256'(sb_q.size()), 256'd0);
  endtask

  // Full job: latch, accept one nonce every gap cycles, check drain and exhaustion timing
  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input int gap,
                         input string tag);
    logic [31:0] n;
    logic [31:0] cnt;
    n   = s;
    cnt = e - s + 32'd1;
    load_job(s, e);
    bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    chk({tag, "_ack"}, 256'(bus.job_ack), 256'd1);
    chk({tag, "_x"}, bus.dsha_X, {8{s ^ 32'hA5A5_0000}});
    chk({tag, "_y"}, 256'(bus.dsha_Y), 256'({3{~s}}));
    chk({tag, "_busy"}, 256'(bus.busy), 256'd1);
    chk({tag, "_exh_clr"}, 256'(bus.exhausted), 256'd0);
    for (int k = 0; k < 64 && k < int'(cnt); k++) begin
      chk({tag, "_nonce"}, 256'(bus.dsha_nonce), 256'(n));
      bus.dsha_accepted = 1'b1;
      tick();
      bus.dsha_accepted = 1'b0;
      if (k == 0) chk({tag, "_ack_pulse"}, 256'(bus.job_ack), 256'd0);
      if (n != e) begin
        n = n + 32'd1;
        for (int g = 1; g < gap; g++) begin
          chk({tag, "_nonce_hold"}, 256'(bus.dsha_nonce), 256'(n));
          tick();
        end
      end
    end
    chk({tag, "_end_hold"}, 256'(bus.dsha_nonce), 256'(e));
    chk({tag, "_drain_busy"}, 256'(bus.busy), 256'd1);
    repeat (PD-1) tick();
    chk({tag, "_exh_early"}, 256'(bus.exhausted), 256'd0);
    tick();
    chk({tag, "_exh"}, 256'(bus.exhausted), 256'd1);
    chk({tag, "_idle_busy"}, 256'(bus.busy), 256'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    n_cmp = 0;
    n_err = 0;
    n_res = 0;
    rst = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_data = {JOB_W{1'b0}};
    bus.dsha_accepted = 1'b0;
    bus.res_ready = 1'b1;
    repeat (2) tick();
    chk("rst_ack", 256'(bus.job_ack), 256'd0);
    chk("rst_busy", 256'(bus.busy), 256'd0);
    chk("rst_exh", 256'(bus.exhausted), 256'd0);
    chk("rst_ovf", 256'(bus.overflow), 256'd0);
    chk("rst_valid", 256'(bus.res_valid), 256'd0);
    chk("rst_nonce", 256'(bus.dsha_nonce), 256'd0);
    chk("rst_x", bus.dsha_X, 256'd0);
    rst = 1'b0;
    tick();

    // Basic range, accept every cycle, no hits
    hit_list = {};
    run_job(32'h10, 32'h13, 1, "basic");

    // One hit held for 5 cycles by the datapath -> reported once
    hit_list = {32'h12};
    expect_hit(32'h12);
    base = n_res;
    run_job(32'h10, 32'h13, 5, "dedupe");
    wait_sb("dedupe_sb");
    chk("dedupe_count", 256'(n_res - base), 256'd1);

    // Wrapping range
    hit_list = {32'h0};
    expect_hit(32'h0);
    run_job(32'hFFFF_FFFE, 32'h1, 1, "wrap");
    wait_sb("wrap_sb");

    // Abort after 20 accepts: old 0x15 hit is flushed, new-job hit is reported
    hit_list = {32'h15, 32'h203};
    load_job(32'h2, 32'h40);
    bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("abort_a_nonce", 256'(bus.dsha_nonce), 256'(32'h2 + 32'(k)));
      bus.dsha_accepted = 1'b1;
      tick();
    end
    expect_hit(32'h203);
    base = n_res;
    run_job(32'h200, 32'h205, 1, "abort_b");
    wait_sb("abort_sb");
    chk("abort_count", 256'(n_res - base), 256'd1);

    // Overflow: 5 hits, nobody pops
    bus.res_ready = 1'b0;
    hit_list = {32'h300, 32'h301, 32'h302, 32'h303, 32'h304};
    for (int k = 0; k < 4; k++) expect_hit(32'h300 + 32'(k));
    run_job(32'h300, 32'h304, 1, "ovf");
    chk("ovf_flag", 256'(bus.overflow), 256'd1);
    chk("ovf_valid", 256'(bus.res_valid), 256'd1);
    chk("ovf_head", 256'(bus.res_nonce), 256'h300);
    run_job(32'h400, 32'h400, 1, "single");
    chk("ovf_cleared", 256'(bus.overflow), 256'd0);
    chk("ovf_kept", 256'(bus.res_valid), 256'd1);
    base = n_res;
    bus.res_ready = 1'b1;
    wait_sb("ovf_sb");
    chk("ovf_count", 256'(n_res - base), 256'd4);

    // Asynchronous reset in the middle of DRAIN with a queued hit
    bus.res_ready = 1'b0;
    hit_list = {32'h500};
    load_job(32'h500, 32'h501);
    bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    bus.dsha_accepted = 1'b1;
    tick();
    bus.dsha_accepted = 1'b0;
    repeat (10) tick();
    chk("rst2_nonce", 256'(bus.dsha_nonce), 256'h501);
    bus.dsha_accepted = 1'b1;
    tick();
    bus.dsha_accepted = 1'b0;
    for (int i = 0; i < 200 && !bus.res_valid; i++) tick();
    chk("rst2_pre_valid", 256'(bus.res_valid), 256'd1);
    chk("rst2_pre_busy", 256'(bus.busy), 256'd1);
    rst = 1'b1;
    #1;
    chk("rst2_valid", 256'(bus.res_valid), 256'd0);
    chk("rst2_busy", 256'(bus.busy), 256'd0);
    chk("rst2_exh", 256'(bus.exhausted), 256'd0);
    chk("rst2_ovf", 256'(bus.overflow), 256'd0);
    chk("rst2_nonce0", 256'(bus.dsha_nonce), 256'd0);
    chk("rst2_x", bus.dsha_X, 256'd0);
    chk("rst2_y", 256'(bus.dsha_Y), 256'd0);
    chk("rst2_rhash", bus.res_hash, 256'd0);
    chk("rst2_rnonce", 256'(bus.res_nonce), 256'd0);
    tick();
    rst = 1'b0;
    tick();
    bus.dsha_accepted = 1'b1;
    tick();
    bus.dsha_accepted = 1'b0;
    chk("idle_nonce", 256'(bus.dsha_nonce), 256'd0);
    chk("idle_busy", 256'(bus.busy), 256'd0);
    chk("idle_valid", 256'(bus.res_valid), 256'd0);
    bus.res_ready = 1'b1;
    repeat (3) tick();
    chk("final_sb", 256'(sb_q.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
